calc_entry_fsm: RTL

Consumer end of the keypad path. Takes the keypad encoder's 4-bit keycode and the poller's key-pressed level, and turns each new keypress into calculator actions: digit entry, add/subtract, equals, backspace and clear. It produces a 10-bit value for bin2bcd_10bit and the seven-segment chain, and takes over the keypress-counter logic at top level.

---
 rtl/calc_pkg.sv | 26 ++
 rtl/calc_alu.sv | 39 +++
 rtl/calc_entry_fsm.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared constants and encodings for the keypad calculator.
// Keycodes, FSM states, operator codes and default range limit.
package calc_pkg;

  localparam int DEF_MAX_VALUE = 999;

  localparam logic [3:0] KEY_ADD  = 4'hA;
  localparam logic [3:0] KEY_SUB  = 4'hB;
  localparam logic [3:0] KEY_BKSP = 4'hC;
  localparam logic [3:0] KEY_CLR  = 4'hD;
  localparam logic [3:0] KEY_EQ   = 4'hF;

  typedef enum logic [1:0] {
    S_OPA,
    S_OPB,
    S_RESULT,
    S_ERROR
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10
  } op_t;

endpackage

// File: rtl/calc_alu.sv
// Combinational add/subtract with range check for the calculator.
// Ports: acc, cur, op in; result, out_of_range out.
module calc_alu
  import calc_pkg::*;
#(
  parameter int WIDTH     = 10,
  parameter int MAX_VALUE = DEF_MAX_VALUE
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] cur,
  input  op_t              op,
  output logic [WIDTH-1:0] result,
  output logic             out_of_range
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, acc} + {1'b0, cur};
  assign diff = {1'b0, acc} - {1'b0, cur};

  always_comb begin
    result       = cur;
    out_of_range = 1'b0;
    unique case (op)
      OP_ADD: begin
        result       = sum[WIDTH-1:0];
        out_of_range = sum > (WIDTH+1)'(MAX_VALUE);
      end
      OP_SUB: begin
        result       = diff[WIDTH-1:0];
        // borrow out of the extra bit means a negative result
        out_of_range = diff[WIDTH];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/calc_entry_fsm.sv
// Keypad calculator entry FSM: turns keypress edges into digit entry,
// add/sub, equals, backspace and clear. Ports: clk, reset, key_pressed,
// keycode in; display_value, error, op_pending, key_accepted/rejected out.
module calc_entry_fsm
  import calc_pkg::*;
#(
  parameter int WIDTH     = 10,
  parameter int MAX_VALUE = DEF_MAX_VALUE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_pressed,
  input  logic [3:0]       keycode,
  output logic [WIDTH-1:0] display_value,
  output logic             error,
  output logic [1:0]       op_pending,
  output logic             key_accepted,
  output logic             key_rejected
);

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic             empty_q, empty_d;
  logic             key_prev;
  logic             evt;
  logic             rej;
  logic [WIDTH-1:0] disp_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_oor;
  logic [WIDTH+3:0] dval;
  logic             dig_ok;
  logic             is_dig, is_op, is_bksp, is_clr, is_eq;
  op_t              key_op;

  calc_alu #(
    .WIDTH    (WIDTH),
    .MAX_VALUE(MAX_VALUE)
  ) u_alu (
    .acc         (acc_q),
    .cur         (cur_q),
    .op          (op_q),
    .result      (alu_res),
    .out_of_range(alu_oor)
  );

  assign evt     = key_pressed & ~key_prev;
  assign is_dig  = keycode <= 4'd9;
  assign is_op   = (keycode == KEY_ADD) || (keycode == KEY_SUB);
  assign is_bksp = keycode == KEY_BKSP;
  assign is_clr  = keycode == KEY_CLR;
  assign is_eq   = keycode == KEY_EQ;
  assign key_op  = (keycode == KEY_SUB) ? OP_SUB : OP_ADD;

  assign dval   = {4'b0, cur_q} * (WIDTH+4)'(10)
                + (WIDTH+4)'(keycode);
  assign dig_ok = dval <= (WIDTH+4)'(MAX_VALUE);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    cur_d   = cur_q;
    empty_d = empty_q;
    rej     = 1'b0;
    if (evt) begin
      unique case (1'b1)
        is_clr: begin
          state_d = S_OPA;
          op_d    = OP_NONE;
          acc_d   = '0;
          cur_d   = '0;
          empty_d = 1'b0;
        end
        is_dig: begin
          unique case (state_q)
            S_OPA, S_OPB: begin
              if (dig_ok) begin
                cur_d   = dval[WIDTH-1:0];
                empty_d = 1'b0;
              end else begin
                rej = 1'b1;
              end
            end
            S_RESULT: begin
              cur_d   = WIDTH'(keycode);
              acc_d   = '0;
              empty_d = 1'b0;
              state_d = S_OPA;
            end
            default: rej = 1'b1;
          endcase
        end
        is_op: begin
          unique case (state_q)
            S_OPA, S_RESULT: begin
              if (state_q == S_OPA) acc_d = cur_q;
              cur_d   = '0;
              op_d    = key_op;
              empty_d = 1'b1;
              state_d = S_OPB;
            end
            S_OPB: begin
              if (empty_q) begin
                op_d = key_op;
              end else if (alu_oor) begin
                op_d    = OP_NONE;
                state_d = S_ERROR;
              end else begin
                acc_d   = alu_res;
                cur_d   = '0;
                op_d    = key_op;
                empty_d = 1'b1;
              end
            end
            default: rej = 1'b1;
          endcase
        end
        is_bksp: begin
          if (state_q == S_OPA || state_q == S_OPB)
            cur_d = cur_q / WIDTH'(10);
          else
            rej = 1'b1;
        end
        is_eq: begin
          unique case (state_q)
            S_OPB: begin
              op_d = OP_NONE;
              if (alu_oor) begin
                state_d = S_ERROR;
              end else begin
                acc_d   = alu_res;
                state_d = S_RESULT;
              end
            end
            S_OPA: begin
              acc_d   = cur_q;
              state_d = S_RESULT;
            end
            default: rej = 1'b1;
          endcase
        end
        default: rej = 1'b1;
      endcase
    end
  end

  always_comb begin
    disp_d = '0;
    unique case (state_d)
      S_OPA:    disp_d = cur_d;
      S_OPB:    disp_d = empty_d ? acc_d : cur_d;
      S_RESULT: disp_d = acc_d;
      default:  disp_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // held key at reset release must not count as a new press
      key_prev      <= 1'b1;
      state_q       <= S_OPA;
      op_q          <= OP_NONE;
      acc_q         <= '0;
      cur_q         <= '0;
      empty_q       <= 1'b0;
      display_value <= '0;
      error         <= 1'b0;
      op_pending    <= 2'b00;
      key_accepted  <= 1'b0;
      key_rejected  <= 1'b0;
    end else begin
      key_prev      <= key_pressed;
      state_q       <= state_d;
      op_q          <= op_d;
      acc_q         <= acc_d;
      cur_q         <= cur_d;
      empty_q       <= empty_d;
      display_value <= disp_d;
      error         <= state_d == S_ERROR;
      op_pending    <= op_d;
      key_accepted  <= evt & ~rej;
      key_rejected  <= evt & rej;
    end
  end

endmodule
